issue_g: RTL



---
 rtl/datapath_pkg.sv | 42 ++++
 rtl/issue_g_if.sv | 23 ++
 rtl/tag_tracker.sv | 53 +++++
 rtl/issue_g.sv | 116 +++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types: FUST_G table row/status, producer tags and the
// general-class issue state encoding.
package datapath_pkg;

    // Producer tags; FU_NONE means the operand is already available.
    typedef enum logic [1:0] {
        FU_NONE = 2'd0,
        FU_ALU  = 2'd1,
        FU_MLS  = 2'd2,
        FU_TC   = 2'd3
    } fu_tag_t;

    typedef struct packed {
        logic [7:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
    } fust_g_row_t;

    typedef struct packed {
        logic        busy;
        fust_g_row_t row;
        fu_tag_t     t1;
        fu_tag_t     t2;
        fu_tag_t     t3;
    } fust_g_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READ  = 2'd2,
        ST_ISSUE = 2'd3
    } issue_g_state_t;

    // A writeback matches a tag only when valid and the tag names a real producer.
    function automatic logic tag_hit(input fu_tag_t tag, input logic wb_valid,
                                     input logic [1:0] wb_fu);
        return wb_valid && (tag != FU_NONE) && (tag == fu_tag_t'(wb_fu));
    endfunction

endpackage

// File: rtl/issue_g_if.sv
// Issue-to-general-FU handshake: held row plus registered operands.
interface issue_g_if
    import datapath_pkg::*;
#(
    parameter int unsigned WORD_W = 32
);
    logic              fu_valid;
    logic              fu_ready;
    fust_g_row_t       fu_row;
    logic [WORD_W-1:0] fu_op1;
    logic [WORD_W-1:0] fu_op2;
    logic [WORD_W-1:0] fu_op3;

    modport master (
        output fu_valid, fu_row, fu_op1, fu_op2, fu_op3,
        input  fu_ready
    );

    modport slave (
        input  fu_valid, fu_row, fu_op1, fu_op2, fu_op3,
        output fu_ready
    );
endinterface

// File: rtl/tag_tracker.sv
// Three source-tag registers: capture with writeback bypass, writeback
// clearing while held, flush, and a combinational all-ready indication
// that already reflects this cycle's broadcast.
module tag_tracker
    import datapath_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  fu_tag_t    t1_in,
    input  fu_tag_t    t2_in,
    input  fu_tag_t    t3_in,
    input  logic       wb_valid,
    input  logic [1:0] wb_fu,
    input  logic       flush,
    output logic       all_ready
);

    fu_tag_t tag_q   [3];
    fu_tag_t tag_in  [3];
    fu_tag_t cleared [3];
    fu_tag_t captured[3];

    assign tag_in[0] = t1_in;
    assign tag_in[1] = t2_in;
    assign tag_in[2] = t3_in;

    // Apply this cycle's broadcast to both the held tags and incoming tags.
    always_comb begin
        all_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            cleared[i]  = tag_hit(tag_q[i], wb_valid, wb_fu) ? FU_NONE : tag_q[i];
            captured[i] = tag_hit(tag_in[i], wb_valid, wb_fu) ? FU_NONE : tag_in[i];
            if (cleared[i] != FU_NONE) begin
                all_ready = 1'b0;
            end
        end
    end

    // Tag registers: reset/flush clear, capture loads bypassed tags, else clear on hit.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (rst || flush) begin
                tag_q[i] <= FU_NONE;
            end else if (capture) begin
                tag_q[i] <= captured[i];
            end else begin
                tag_q[i] <= cleared[i];
            end
        end
    end

endmodule

// File: rtl/issue_g.sv
// Issue stage for the general functional-unit class. Holds one FUST_G row
// until its source tags clear, reads the register file, then offers the
// instruction to the general FU with a valid/ready handshake.
module issue_g
    import datapath_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5
)(
    input  logic              CLK,
    input  logic              rst,
    input  fust_g_t           fust,
    output logic              busy,
    input  logic              wb_valid,
    input  logic [1:0]        wb_fu,
    input  logic              flush,
    output logic              rf_ren,
    output logic [REG_AW-1:0] rf_ra1,
    output logic [REG_AW-1:0] rf_ra2,
    output logic [REG_AW-1:0] rf_ra3,
    input  logic [WORD_W-1:0] rf_rd1,
    input  logic [WORD_W-1:0] rf_rd2,
    input  logic [WORD_W-1:0] rf_rd3,
    issue_g_if.master         fu
);

    issue_g_state_t state_q;
    issue_g_state_t state_d;
    fust_g_row_t    row_q;
    logic           capture;
    logic           all_ready;

    tag_tracker u_tags (
        .clk       (CLK),
        .rst       (rst),
        .capture   (capture),
        .t1_in     (fust.t1),
        .t2_in     (fust.t2),
        .t3_in     (fust.t3),
        .wb_valid  (wb_valid),
        .wb_fu     (wb_fu),
        .flush     (flush),
        .all_ready (all_ready)
    );

    // Next-state and capture decode; flush overrides everything including the handshake.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fust.busy) begin
                    capture = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (all_ready) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (fu.fu_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            capture = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Held row register, loaded only on capture so it stays stable through issue.
    always_ff @(posedge CLK) begin
        if (rst) begin
            row_q <= '0;
        end else if (capture) begin
            row_q <= fust.row;
        end
    end

    // Operand registers sample the register file on the edge leaving READ.
    always_ff @(posedge CLK) begin
        if (rst) begin
            fu.fu_op1 <= '0;
            fu.fu_op2 <= '0;
            fu.fu_op3 <= '0;
        end else if (state_q == ST_READ) begin
            fu.fu_op1 <= rf_rd1;
            fu.fu_op2 <= rf_rd2;
            fu.fu_op3 <= rf_rd3;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign rf_ren      = (state_q == ST_READ);
    assign fu.fu_valid = (state_q == ST_ISSUE);
    assign fu.fu_row   = row_q;
    assign rf_ra1      = REG_AW'(row_q.rs1);
    assign rf_ra2      = REG_AW'(row_q.rs2);
    assign rf_ra3      = REG_AW'(row_q.rs3);

endmodule
